// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared types and default geometry for the matrix processing unit
//
// Contents:
//   MPU_M / MPU_N          legacy fixed matrix shape (2x3)
//   MPU_MAX_M / MPU_MAX_N  default maximum runtime matrix shape
//   MPU_FP                 default element width
//   mpu_operation_t        host command opcode (NOP/LOAD/STORE)
//   stream_state_t         load/store engine state
//   max_dim()              helper for sizing dimension fields
package mpu_pkg;

    localparam int MPU_M     = 2;
    localparam int MPU_N     = 3;
    localparam int MPU_MAX_M = 4;
    localparam int MPU_MAX_N = 4;
    localparam int MPU_FP    = 32;

    typedef enum logic [1:0] {
        MPU_NOP   = 2'd0,
        MPU_LOAD  = 2'd1,
        MPU_STORE = 2'd2
    } mpu_operation_t;

    typedef enum logic [1:0] {
        STREAM_IDLE  = 2'd0,
        STREAM_LOAD  = 2'd1,
        STREAM_STORE = 2'd2
    } stream_state_t;

    function automatic int max_dim(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mpu_matrix_regfile.sv
// rtl/mpu_matrix_regfile.sv - matrix register file with per-register valid bit and dims
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   we, waddr, wrow, wcol, wdata   single element write port
//   re, raddr, rrow, rcol, rdata   single element read port, rdata registered
//   set_valid, set_addr,
//   set_rows, set_cols             mark a register loaded and record its dims
//   clr_valid, clr_addr            invalidate a register
//   q_addr, q_valid,
//   q_rows, q_cols                 combinational status lookup
module mpu_matrix_regfile
    import mpu_pkg::*;
#(
    parameter int FP               = MPU_FP,
    parameter int MAX_M            = MPU_MAX_M,
    parameter int MAX_N            = MPU_MAX_N,
    parameter int MATRIX_REGISTERS = 16,
    parameter int REG_BITS         = $clog2(MATRIX_REGISTERS),
    parameter int DIM_BITS         = $clog2(max_dim(MAX_M, MAX_N) + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [REG_BITS-1:0] waddr,
    input  logic [DIM_BITS-1:0] wrow,
    input  logic [DIM_BITS-1:0] wcol,
    input  logic [FP-1:0]       wdata,
    input  logic                re,
    input  logic [REG_BITS-1:0] raddr,
    input  logic [DIM_BITS-1:0] rrow,
    input  logic [DIM_BITS-1:0] rcol,
    output logic [FP-1:0]       rdata,
    input  logic                set_valid,
    input  logic [REG_BITS-1:0] set_addr,
    input  logic [DIM_BITS-1:0] set_rows,
    input  logic [DIM_BITS-1:0] set_cols,
    input  logic                clr_valid,
    input  logic [REG_BITS-1:0] clr_addr,
    input  logic [REG_BITS-1:0] q_addr,
    output logic                q_valid,
    output logic [DIM_BITS-1:0] q_rows,
    output logic [DIM_BITS-1:0] q_cols
);

    localparam int ELEMS    = MAX_M * MAX_N;
    localparam int IDX_BITS = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    logic [FP-1:0]         mem      [MATRIX_REGISTERS][ELEMS];
    logic [MATRIX_REGISTERS-1:0] vld;
    logic [DIM_BITS-1:0]   rows_st  [MATRIX_REGISTERS];
    logic [DIM_BITS-1:0]   cols_st  [MATRIX_REGISTERS];
    logic [IDX_BITS-1:0]   widx;
    logic [IDX_BITS-1:0]   ridx;

    // Elements live at row * MAX_N + col regardless of the runtime dims.
    assign widx = IDX_BITS'(int'(wrow) * MAX_N + int'(wcol));
    assign ridx = IDX_BITS'(int'(rrow) * MAX_N + int'(rcol));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < MATRIX_REGISTERS; r++) begin
                for (int e = 0; e < ELEMS; e++) begin
                    mem[r][e] <= '0;
                end
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[waddr][widx] <= wdata;
            end
            if (re) begin
                rdata <= mem[raddr][ridx];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int r = 0; r < MATRIX_REGISTERS; r++) begin
                rows_st[r] <= '0;
                cols_st[r] <= '0;
            end
        end else begin
            if (clr_valid) begin
                vld[clr_addr] <= 1'b0;
            end
            if (set_valid) begin
                vld[set_addr]     <= 1'b1;
                rows_st[set_addr] <= set_rows;
                cols_st[set_addr] <= set_cols;
            end
        end
    end

    assign q_valid = vld[q_addr];
    assign q_rows  = rows_st[q_addr];
    assign q_cols  = cols_st[q_addr];

endmodule

// File: rtl/mpu_matrix_stream.sv
// rtl/mpu_matrix_stream.sv - one-command-at-a-time matrix load/store streaming engine
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   op_i, op_valid_i, op_ready_o      command (NOP/LOAD/STORE) handshake
//   reg_addr_i                        target matrix register
//   rows_i, cols_i                    LOAD dimensions
//   transpose_i                       STORE emits column-major
//   in_data_i, in_valid_i, in_ready_o load element stream
//   out_data_o, out_valid_o,
//   out_ready_i, out_last_o           store element stream
//   done_o                            pulse after a LOAD/STORE completes
//   error_o                           pulse after a command is rejected
module mpu_matrix_stream
    import mpu_pkg::*;
#(
    parameter int FP               = MPU_FP,
    parameter int MAX_M            = MPU_MAX_M,
    parameter int MAX_N            = MPU_MAX_N,
    parameter int MATRIX_REGISTERS = 16,
    parameter int REG_BITS         = $clog2(MATRIX_REGISTERS),
    parameter int DIM_BITS         = $clog2(max_dim(MAX_M, MAX_N) + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          op_i,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  logic [REG_BITS-1:0] reg_addr_i,
    input  logic [DIM_BITS-1:0] rows_i,
    input  logic [DIM_BITS-1:0] cols_i,
    input  logic                transpose_i,
    input  logic [FP-1:0]       in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [FP-1:0]       out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_last_o,
    output logic                done_o,
    output logic                error_o
);

    localparam logic [DIM_BITS-1:0] DIM_ZERO  = '0;
    localparam logic [DIM_BITS-1:0] DIM_ONE   = DIM_BITS'(1);
    localparam logic [DIM_BITS-1:0] DIM_MAX_M = DIM_BITS'(MAX_M);
    localparam logic [DIM_BITS-1:0] DIM_MAX_N = DIM_BITS'(MAX_N);

    stream_state_t       state;
    stream_state_t       state_nxt;

    logic [REG_BITS-1:0] cur_reg;
    logic [DIM_BITS-1:0] cur_rows;
    logic [DIM_BITS-1:0] cur_cols;
    logic                cur_tr;
    logic [DIM_BITS-1:0] row_cnt;
    logic [DIM_BITS-1:0] col_cnt;
    logic [DIM_BITS-1:0] step_row;
    logic [DIM_BITS-1:0] step_col;
    logic                last_row;
    logic                last_col;
    logic                last_elem;
    logic                dims_ok;

    logic                start_load;
    logic                start_store;
    logic                advance;
    logic                done_nxt;
    logic                error_nxt;
    logic                done_q;
    logic                error_q;

    logic                rf_we;
    logic                rf_re;
    logic [REG_BITS-1:0] rf_raddr;
    logic [DIM_BITS-1:0] rf_rrow;
    logic [DIM_BITS-1:0] rf_rcol;
    logic                rf_set;
    logic                rf_clr;
    logic                q_valid;
    logic [DIM_BITS-1:0] q_rows;
    logic [DIM_BITS-1:0] q_cols;

    assign last_row  = (row_cnt == cur_rows - DIM_ONE);
    assign last_col  = (col_cnt == cur_cols - DIM_ONE);
    // Column-major traversal also finishes on (rows-1, cols-1).
    assign last_elem = last_row && last_col;

    assign dims_ok = (rows_i != DIM_ZERO) && (rows_i <= DIM_MAX_M) &&
                     (cols_i != DIM_ZERO) && (cols_i <= DIM_MAX_N);

    // Position following the current one; only a transposed STORE walks columns.
    always_comb begin
        step_row = row_cnt;
        step_col = col_cnt;
        if ((state == STREAM_STORE) && cur_tr) begin
            if (last_row) begin
                step_row = DIM_ZERO;
                step_col = col_cnt + DIM_ONE;
            end else begin
                step_row = row_cnt + DIM_ONE;
            end
        end else begin
            if (last_col) begin
                step_col = DIM_ZERO;
                step_row = row_cnt + DIM_ONE;
            end else begin
                step_col = col_cnt + DIM_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= STREAM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        op_ready_o  = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_last_o  = 1'b0;
        start_load  = 1'b0;
        start_store = 1'b0;
        advance     = 1'b0;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        rf_we       = 1'b0;
        rf_re       = 1'b0;
        rf_raddr    = cur_reg;
        rf_rrow     = step_row;
        rf_rcol     = step_col;
        rf_set      = 1'b0;
        rf_clr      = 1'b0;

        case (state)
            STREAM_IDLE: begin
                op_ready_o = 1'b1;
                if (op_valid_i) begin
                    case (mpu_operation_t'(op_i))
                        MPU_LOAD: begin
                            if (dims_ok) begin
                                start_load = 1'b1;
                                rf_clr     = 1'b1;
                                state_nxt  = STREAM_LOAD;
                            end else begin
                                error_nxt = 1'b1;
                            end
                        end
                        MPU_STORE: begin
                            if (q_valid) begin
                                // Prefetch element (0,0) so it is on out_data_o next cycle.
                                start_store = 1'b1;
                                rf_re       = 1'b1;
                                rf_raddr    = reg_addr_i;
                                rf_rrow     = DIM_ZERO;
                                rf_rcol     = DIM_ZERO;
                                state_nxt   = STREAM_STORE;
                            end else begin
                                error_nxt = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            STREAM_LOAD: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    rf_we   = 1'b1;
                    advance = 1'b1;
                    if (last_elem) begin
                        rf_set    = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = STREAM_IDLE;
                    end
                end
            end
            STREAM_STORE: begin
                out_valid_o = 1'b1;
                out_last_o  = last_elem;
                if (out_ready_i) begin
                    if (last_elem) begin
                        done_nxt  = 1'b1;
                        state_nxt = STREAM_IDLE;
                    end else begin
                        // Fetch the next element now; the read port holds rdata on stalls.
                        advance = 1'b1;
                        rf_re   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = STREAM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_reg  <= '0;
            cur_rows <= '0;
            cur_cols <= '0;
            cur_tr   <= 1'b0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q  <= done_nxt;
            error_q <= error_nxt;
            if (start_load) begin
                cur_reg  <= reg_addr_i;
                cur_rows <= rows_i;
                cur_cols <= cols_i;
                cur_tr   <= 1'b0;
                row_cnt  <= '0;
                col_cnt  <= '0;
            end else if (start_store) begin
                cur_reg  <= reg_addr_i;
                cur_rows <= q_rows;
                cur_cols <= q_cols;
                cur_tr   <= transpose_i;
                row_cnt  <= '0;
                col_cnt  <= '0;
            end else if (advance) begin
                row_cnt <= step_row;
                col_cnt <= step_col;
            end
        end
    end

    assign done_o  = done_q;
    assign error_o = error_q;

    mpu_matrix_regfile #(
        .FP               (FP),
        .MAX_M            (MAX_M),
        .MAX_N            (MAX_N),
        .MATRIX_REGISTERS (MATRIX_REGISTERS),
        .REG_BITS         (REG_BITS),
        .DIM_BITS         (DIM_BITS)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .we        (rf_we),
        .waddr     (cur_reg),
        .wrow      (row_cnt),
        .wcol      (col_cnt),
        .wdata     (in_data_i),
        .re        (rf_re),
        .raddr     (rf_raddr),
        .rrow      (rf_rrow),
        .rcol      (rf_rcol),
        .rdata     (out_data_o),
        .set_valid (rf_set),
        .set_addr  (cur_reg),
        .set_rows  (cur_rows),
        .set_cols  (cur_cols),
        .clr_valid (rf_clr),
        .clr_addr  (reg_addr_i),
        .q_addr    (reg_addr_i),
        .q_valid   (q_valid),
        .q_rows    (q_rows),
        .q_cols    (q_cols)
    );

endmodule

// File: tb/tb_mpu_matrix_stream.sv
// tb/tb_mpu_matrix_stream.sv - self-checking bench for mpu_matrix_stream
module tb_mpu_matrix_stream;
    import mpu_pkg::*;

    localparam int MM   = 4;
    localparam int MN   = 4;
    localparam int NREG = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  op_i;
    logic        op_valid_i;
    logic        op_ready_o;
    logic [3:0]  reg_addr_i;
    logic [2:0]  rows_i;
    logic [2:0]  cols_i;
    logic        transpose_i;
    logic [31:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        done_o;
    logic        error_o;

    mpu_matrix_stream dut (
        .clk         (clk),
        .rst         (rst),
        .op_i        (op_i),
        .op_valid_i  (op_valid_i),
        .op_ready_o  (op_ready_o),
        .reg_addr_i  (reg_addr_i),
        .rows_i      (rows_i),
        .cols_i      (cols_i),
        .transpose_i (transpose_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: matrix contents by (row, col), validity and dims per register.
    logic [31:0] m_mem   [NREG][MM][MN];
    bit          m_valid [NREG];
    int          m_rows  [NREG];
    int          m_cols  [NREG];

    logic [31:0] fixed_vals [6];

    typedef struct {
        logic [1:0] op;
        int         ra;
        int         rows;
        int         cols;
        logic       exp_err;
    } vec_t;
    vec_t tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] op, input int ra, input int nr, input int nc,
                             input logic tr);
        op_i        = op;
        reg_addr_i  = 4'(ra);
        rows_i      = 3'(nr);
        cols_i      = 3'(nc);
        transpose_i = tr;
        op_valid_i  = 1'b1;
    endtask

    function automatic bit dims_legal(input int nr, input int nc);
        return (nr >= 1) && (nr <= MM) && (nc >= 1) && (nc <= MN);
    endfunction

    task automatic do_load(input int ra, input int nr, input int nc, input bit fixed, input bit gaps);
        int k;
        int cycles;
        drive_cmd(MPU_LOAD, ra, nr, nc, 1'b0);
        step();
        op_valid_i = 1'b0;
        m_valid[ra] = 1'b0;
        k = 0;
        cycles = 0;
        while (k < nr * nc && cycles < 200) begin
            chk_bit("load_in_ready", in_ready_o, 1'b1);
            chk_bit("load_op_ready", op_ready_o, 1'b0);
            chk_bit("load_no_done", done_o, 1'b0);
            in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data_i  = fixed ? fixed_vals[k] : $urandom;
            if (in_valid_i) begin
                m_mem[ra][k / nc][k % nc] = in_data_i;
                k++;
            end
            step();
            cycles++;
        end
        in_valid_i = 1'b0;
        chk_bit("load_finished", k == nr * nc, 1'b1);
        if (!gaps) chk_word("load_cycles", cycles, nr * nc);
        chk_bit("load_done", done_o, 1'b1);
        chk_bit("load_idle_op_ready", op_ready_o, 1'b1);
        chk_bit("load_in_ready_drop", in_ready_o, 1'b0);
        m_valid[ra] = 1'b1;
        m_rows[ra]  = nr;
        m_cols[ra]  = nc;
        step();
        chk_bit("load_done_pulse", done_o, 1'b0);
    endtask

    // rmode: 0 sink always ready, 1 ready toggles 1,0,1,0..., 2 random.
    task automatic do_store(input int ra, input logic tr, input int rmode);
        logic [31:0] exp_q[$];
        int          idx;
        int          cycles;
        logic        tog;
        exp_q = {};
        if (!tr) begin
            for (int r = 0; r < m_rows[ra]; r++)
                for (int c = 0; c < m_cols[ra]; c++) exp_q.push_back(m_mem[ra][r][c]);
        end else begin
            for (int c = 0; c < m_cols[ra]; c++)
                for (int r = 0; r < m_rows[ra]; r++) exp_q.push_back(m_mem[ra][r][c]);
        end
        drive_cmd(MPU_STORE, ra, 0, 0, tr);
        step();
        op_valid_i = 1'b0;
        idx = 0;
        cycles = 0;
        tog = 1'b1;
        while (idx < exp_q.size() && cycles < 400) begin
            chk_bit("store_valid", out_valid_o, 1'b1);
            chk_word($sformatf("store_data[%0d]", idx), out_data_o, exp_q[idx]);
            chk_bit("store_last", out_last_o, idx == exp_q.size() - 1);
            chk_bit("store_op_ready", op_ready_o, 1'b0);
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = tog;
                default: out_ready_i = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            if (out_ready_i) idx++;
            step();
            cycles++;
        end
        out_ready_i = 1'b0;
        chk_bit("store_finished", idx == exp_q.size(), 1'b1);
        if (rmode == 0) chk_word("store_cycles", cycles, exp_q.size());
        chk_bit("store_valid_drop", out_valid_o, 1'b0);
        chk_bit("store_last_drop", out_last_o, 1'b0);
        chk_bit("store_done", done_o, 1'b1);
        chk_bit("store_error_quiet", error_o, 1'b0);
        step();
        chk_bit("store_done_pulse", done_o, 1'b0);
    endtask

    task automatic do_err(input logic [1:0] op, input int ra, input int nr, input int nc);
        drive_cmd(op, ra, nr, nc, 1'b0);
        step();
        op_valid_i = 1'b0;
        chk_bit("err_pulse", error_o, 1'b1);
        chk_bit("err_no_done", done_o, 1'b0);
        chk_bit("err_op_ready", op_ready_o, 1'b1);
        chk_bit("err_in_ready", in_ready_o, 1'b0);
        chk_bit("err_out_valid", out_valid_o, 1'b0);
        step();
        chk_bit("err_pulse_end", error_o, 1'b0);
    endtask

    initial begin
        int   kind;
        int   ra;
        int   nr;
        int   nc;
        logic tr;

        rst = 1'b1;
        op_i = 2'd0; op_valid_i = 1'b0; reg_addr_i = '0; rows_i = '0; cols_i = '0;
        transpose_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            m_valid[r] = 1'b0; m_rows[r] = 0; m_cols[r] = 0;
        end
        fixed_vals[0] = 32'h3F800000; fixed_vals[1] = 32'h40000000;
        fixed_vals[2] = 32'h40400000; fixed_vals[3] = 32'h40800000;
        fixed_vals[4] = 32'h40A00000; fixed_vals[5] = 32'h40C00000;

        tbl[0] = '{MPU_LOAD,  2, 0,      3,      1'b1};
        tbl[1] = '{MPU_LOAD,  2, 2,      MN + 1, 1'b1};
        tbl[2] = '{MPU_STORE, 7, 0,      0,      1'b1};
        tbl[3] = '{MPU_LOAD,  2, MM + 1, 1,      1'b1};
        tbl[4] = '{MPU_LOAD,  2, 3,      0,      1'b1};
        tbl[5] = '{MPU_NOP,   3, 2,      2,      1'b0};
        tbl[6] = '{MPU_STORE, 9, 0,      0,      1'b1};

        repeat (3) step();
        chk_bit("rst_op_ready", op_ready_o, 1'b1);
        chk_bit("rst_in_ready", in_ready_o, 1'b0);
        chk_bit("rst_out_valid", out_valid_o, 1'b0);
        chk_bit("rst_out_last", out_last_o, 1'b0);
        chk_bit("rst_done", done_o, 1'b0);
        chk_bit("rst_error", error_o, 1'b0);
        chk_word("rst_out_data", out_data_o, 32'h0);
        rst = 1'b0;
        step();

        // LOAD 2x3 of 1.0..6.0, then plain and transposed stores.
        do_load(3, 2, 3, 1'b1, 1'b0);
        do_store(3, 1'b0, 0);
        do_store(3, 1'b1, 1);

        // Rejected and no-op commands leave the engine idle.
        for (int i = 0; i < 7; i++) begin
            drive_cmd(tbl[i].op, tbl[i].ra, tbl[i].rows, tbl[i].cols, 1'b0);
            step();
            op_valid_i = 1'b0;
            chk_bit($sformatf("vec%0d_error", i), error_o, tbl[i].exp_err);
            chk_bit($sformatf("vec%0d_op_ready", i), op_ready_o, 1'b1);
            chk_bit($sformatf("vec%0d_in_ready", i), in_ready_o, 1'b0);
            chk_bit($sformatf("vec%0d_out_valid", i), out_valid_o, 1'b0);
            step();
            chk_bit($sformatf("vec%0d_error_end", i), error_o, 1'b0);
        end

        // STORE held on the command port during a LOAD is ignored until re-presented.
        drive_cmd(MPU_LOAD, 3, 1, 2, 1'b0);
        step();
        m_valid[3] = 1'b0;
        drive_cmd(MPU_STORE, 3, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_bit("busy_op_ready", op_ready_o, 1'b0);
            chk_bit("busy_in_ready", in_ready_o, 1'b1);
            chk_bit("busy_out_valid", out_valid_o, 1'b0);
            in_valid_i = (k != 1);
            in_data_i  = $urandom;
            if (k == 0) m_mem[3][0][0] = in_data_i;
            if (k == 2) begin
                m_mem[3][0][1] = in_data_i;
                op_valid_i = 1'b0;
            end
            step();
        end
        in_valid_i = 1'b0;
        chk_bit("busy_done", done_o, 1'b1);
        chk_bit("busy_no_store", out_valid_o, 1'b0);
        chk_bit("busy_idle", op_ready_o, 1'b1);
        m_valid[3] = 1'b1; m_rows[3] = 1; m_cols[3] = 2;
        step();
        do_store(3, 1'b0, 0);

        // Randomised commands checked against the model.
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            ra   = $urandom_range(0, 7);
            if (kind < 4) begin
                nr = $urandom_range(0, 5);
                nc = $urandom_range(0, 5);
                if (dims_legal(nr, nc)) do_load(ra, nr, nc, 1'b0, 1'b1);
                else do_err(MPU_LOAD, ra, nr, nc);
            end else begin
                tr = 1'($urandom_range(0, 1));
                if (m_valid[ra]) do_store(ra, tr, 2);
                else do_err(MPU_STORE, ra, 0, 0);
            end
        end

        // Reset mid-STORE drops the stream with no last flag.
        do_load(1, 1, 1, 1'b0, 1'b0);
        drive_cmd(MPU_STORE, 1, 0, 0, 1'b0);
        step();
        op_valid_i = 1'b0;
        chk_bit("rs_valid", out_valid_o, 1'b1);
        chk_bit("rs_last", out_last_o, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit("rs_valid_drop", out_valid_o, 1'b0);
        chk_bit("rs_last_drop", out_last_o, 1'b0);
        chk_bit("rs_op_ready", op_ready_o, 1'b1);
        step();
        rst = 1'b0;
        for (int r = 0; r < NREG; r++) m_valid[r] = 1'b0;
        step();

        // Reset after 3 of 6 LOAD elements leaves the register invalid.
        drive_cmd(MPU_LOAD, 5, 2, 3, 1'b0);
        step();
        op_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = fixed_vals[k];
            step();
        end
        in_valid_i = 1'b0;
        chk_bit("rl_in_ready", in_ready_o, 1'b1);
        rst = 1'b1;
        #1;
        chk_bit("rl_in_ready_drop", in_ready_o, 1'b0);
        chk_bit("rl_op_ready", op_ready_o, 1'b1);
        chk_bit("rl_done", done_o, 1'b0);
        chk_word("rl_out_data", out_data_o, 32'h0);
        step();
        rst = 1'b0;
        step();
        do_err(MPU_STORE, 5, 0, 0);
        do_err(MPU_STORE, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
